div_seq_unit: RTL



---
 rtl/div_seq_unit_pkg.sv | 14 +
 rtl/div_seq_unit_if.sv | 28 ++
 rtl/div_seq_unit_step.sv | 28 ++
 rtl/div_seq_unit.sv | 117 +++++++++++
 4 files changed

// File: rtl/div_seq_unit_pkg.sv
// Shared definitions for the sequential divider slice.
// State encoding and default operand width.
package div_seq_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        FIX   = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_seq_unit_if.sv
// Divide handshake between the control unit and the divider.
// The control unit is the master; the divider responds.
interface div_seq_unit_if
    import div_seq_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             divzero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, dividend, divisor,
        input  busy, done, divzero, hi_out, lo_out
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, divzero, hi_out, lo_out
    );

endinterface

// File: rtl/div_seq_unit_step.sv
// One restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor magnitude in WIDTH+1 bits.
module div_seq_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             quo_msb,
    input  logic [WIDTH-1:0] dabs,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem, quo_msb};
    assign diff    = shifted - {1'b0, dabs};

    // A clear borrow bit means the trial subtraction fits.
    always_comb begin
        qbit     = ~diff[WIDTH];
        rem_next = shifted[WIDTH-1:0];
        if (~diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_seq_unit.sv
// Sequential signed divider: quotient to LO, remainder to HI,
// truncating toward zero with the remainder signed like the dividend.
module div_seq_unit
    import div_seq_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    div_seq_unit_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dabs;
    logic             sign_q;
    logic             sign_r;
    logic [CW-1:0]    cnt;
    logic             busy;
    logic             done;
    logic             divzero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] rem_next;
    logic             qbit;

    // Unsigned magnitudes, so the most negative value maps to itself.
    assign a_abs = a_reg[WIDTH-1] ? -a_reg : a_reg;
    assign b_abs = b_reg[WIDTH-1] ? -b_reg : b_reg;

    div_seq_unit_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem),
        .quo_msb  (quo[WIDTH-1]),
        .dabs     (dabs),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            rem     <= '0;
            quo     <= '0;
            dabs    <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done    <= 1'b0;
            divzero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg <= bus.dividend;
                        b_reg <= bus.divisor;
                        busy  <= 1'b1;
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (b_reg == '0) begin
                        divzero <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        quo    <= a_abs;
                        rem    <= '0;
                        dabs   <= b_abs;
                        sign_q <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
                        sign_r <= a_reg[WIDTH-1];
                        cnt    <= CW'(WIDTH - 1);
                        state  <= RUN;
                    end
                end
                RUN: begin
                    rem <= rem_next;
                    quo <= {quo[WIDTH-2:0], qbit};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    lo    <= sign_q ? -quo : quo;
                    hi    <= sign_r ? -rem : rem;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.divzero = divzero;
    assign bus.hi_out  = hi;
    assign bus.lo_out  = lo;

endmodule
